// File: rtl/calc_pkg.sv
// Shared definitions for the calc_sequencer batch controller: ALU op codes,
// sequencer states and the command word stored in the FIFO.
package calc_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1001;
   localparam logic [3:0] ALU_SLL = 4'b1010;
   localparam logic [3:0] ALU_SRA = 4'b1101;

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} seq_state_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] operand;
      logic        last;
   } cmd_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
         ALU_SLT, ALU_SRL, ALU_SLL, ALU_SRA: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; pointers wrap naturally because DEPTH is a power of two.
module cmd_fifo
   import calc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_push,
   input  logic i_pop,
   input  cmd_t i_data,
   output cmd_t o_data,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   cmd_t          r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [AW:0]   r_count;
   logic          w_doPush;
   logic          w_doPop;

   assign o_full   = (r_count == FULL_COUNT);
   assign o_empty  = (r_count == '0);
   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;
   assign o_data   = r_mem[r_rdPtr];

   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // A simultaneous push and pop leaves the occupancy unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// Batch controller: buffers (op, operand, last) commands and runs them against a
// 16-bit accumulator through the external 32-bit ALU, one command per two cycles.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [15:0] cmd_operand,
   input  logic        cmd_last,
   input  logic        clear,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_result,
   output logic [15:0] acc,
   output logic        zero_flag,
   output logic        busy,
   output logic        done,
   output logic        err
);

   seq_state_t  r_state;
   seq_state_t  w_nextState;
   logic [3:0]  r_op;
   logic [15:0] r_operand;
   logic        r_last;
   logic [15:0] r_acc;
   logic        r_zero;
   logic        r_busy;
   logic        r_err;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   cmd_t        w_head;
   cmd_t        w_pushData;
   logic [15:0] w_unusedResultHi;

   assign w_pushData       = '{op: cmd_op, operand: cmd_operand, last: cmd_last};
   assign w_unusedResultHi = alu_result[31:16];

   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (cmd_valid),
      .i_pop   (w_pop),
      .i_data  (w_pushData),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign cmd_ready = !w_full;
   assign alu_op1   = {{16{r_acc[15]}}, r_acc};
   assign alu_op2   = {{16{r_operand[15]}}, r_operand};
   assign alu_op    = r_op;
   assign acc       = r_acc;
   assign zero_flag = r_zero;
   assign busy      = r_busy;
   assign err       = r_err;
   assign done      = (r_state == DONE);

   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE:  if (!w_empty) w_nextState = FETCH;
         FETCH: begin
            w_pop       = 1'b1;
            w_nextState = EXEC;
         end
         EXEC: begin
            if (r_last)        w_nextState = DONE;
            else if (!w_empty) w_nextState = FETCH;
            else               w_nextState = IDLE;
         end
         DONE:  w_nextState = IDLE;
      endcase
   end

   // clear takes priority over an EXEC writeback so its result is discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_op      <= '0;
         r_operand <= '0;
         r_last    <= 1'b0;
         r_acc     <= '0;
         r_zero    <= 1'b1;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (r_state == FETCH) begin
            r_op      <= w_head.op;
            r_operand <= w_head.operand;
            r_last    <= w_head.last;
            r_busy    <= 1'b1;
         end
         if (r_state == DONE) r_busy <= 1'b0;
         if (clear) begin
            r_acc  <= '0;
            r_zero <= 1'b1;
            r_err  <= 1'b0;
         end else if (r_state == EXEC) begin
            if (is_legal_op(r_op)) begin
               r_acc  <= alu_result[15:0];
               r_zero <= (alu_result[15:0] == 16'h0000);
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer with a behavioural ALU model
// closing the op1/op2/op -> result loop.
module tb_calc_sequencer;
   import calc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0;
   logic [15:0] cmd_operand = '0;
   logic        cmd_last = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic [15:0] acc;
   logic        zero_flag;
   logic        busy;
   logic        done;
   logic        err;

   int nCompared   = 0;
   int nMismatched = 0;

   calc_sequencer #(.DEPTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_operand (cmd_operand),
      .cmd_last    (cmd_last),
      .clear       (clear),
      .alu_op1     (alu_op1),
      .alu_op2     (alu_op2),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .acc         (acc),
      .zero_flag   (zero_flag),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Shared ALU: shifts act on the full 32-bit sign-extended operand.
   always_comb begin
      alu_result = 32'hDEAD_BEEF;
      case (alu_op)
         ALU_AND: alu_result = alu_op1 & alu_op2;
         ALU_OR:  alu_result = alu_op1 | alu_op2;
         ALU_ADD: alu_result = alu_op1 + alu_op2;
         ALU_SUB: alu_result = alu_op1 - alu_op2;
         ALU_SLT: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
         ALU_SRL: alu_result = alu_op1 >> alu_op2[4:0];
         ALU_SLL: alu_result = alu_op1 << alu_op2[4:0];
         ALU_SRA: alu_result = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
         default: alu_result = 32'hDEAD_BEEF;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected)
      else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one command and holds it until accepted; reports stall cycles.
   task automatic applyStimulus(input logic [3:0] op, input logic [15:0] operand,
                                input logic last, output int stalls);
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_operand = operand;
      cmd_last    = last;
      stalls      = 0;
      while (!cmd_ready && stalls < 50) begin
         tick();
         stalls++;
      end
      tick();
   endtask

   task automatic waitDone(input int budget, output int cycles);
      cycles = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (done) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_acc"}, 32'(acc), 32'h0);
      checkOutput({tag, "_zero"}, 32'(zero_flag), 32'h1);
      checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
      checkOutput({tag, "_done"}, 32'(done), 32'h0);
      checkOutput({tag, "_err"}, 32'(err), 32'h0);
      checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'h1);
      checkOutput({tag, "_op1"}, alu_op1, 32'h0);
      checkOutput({tag, "_op2"}, alu_op2, 32'h0);
      checkOutput({tag, "_aluop"}, 32'(alu_op), 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int stalls;
      int totalStalls;
      int firstStall;
      int cycles;
      logic sawDone;

      // Reset
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      checkResetState("reset");

      // ADD 5, SUB 3 last
      applyStimulus(ALU_ADD, 16'd5, 1'b0, stalls);
      applyStimulus(ALU_SUB, 16'd3, 1'b1, stalls);
      cmd_valid = 1'b0;
      checkOutput("b1_busy_mid", 32'(busy), 32'h0);
      waitDone(20, cycles);
      checkOutput("b1_latency", 32'(cycles), 32'd4);
      checkOutput("b1_acc", 32'(acc), 32'h0002);
      checkOutput("b1_zero", 32'(zero_flag), 32'h0);
      checkOutput("b1_busy_at_done", 32'(busy), 32'h1);
      tick();
      checkOutput("b1_done_pulse", 32'(done), 32'h0);
      checkOutput("b1_busy_after", 32'(busy), 32'h0);

      // Sign extension through the 32-bit ALU
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("clr_acc", 32'(acc), 32'h0);
      checkOutput("clr_zero", 32'(zero_flag), 32'h1);
      applyStimulus(ALU_ADD, 16'hFFFF, 1'b1, stalls);
      cmd_valid = 1'b0;
      waitDone(20, cycles);
      checkOutput("sx_latency", 32'(cycles), 32'd3);
      checkOutput("sx_acc", 32'(acc), 32'hFFFF);
      checkOutput("sx_op1", alu_op1, 32'hFFFF_FFFF);
      checkOutput("sx_op2", alu_op2, 32'hFFFF_FFFF);
      tick();
      applyStimulus(ALU_SRA, 16'd4, 1'b1, stalls);
      cmd_valid = 1'b0;
      waitDone(20, cycles);
      checkOutput("sra_acc", 32'(acc), 32'hFFFF);
      checkOutput("sra_op2", alu_op2, 32'h0000_0004);
      checkOutput("sra_aluop", 32'(alu_op), 32'(ALU_SRA));
      tick();
      applyStimulus(ALU_SRL, 16'd4, 1'b1, stalls);
      cmd_valid = 1'b0;
      waitDone(20, cycles);
      checkOutput("srl_acc", 32'(acc), 32'hFFFF);
      checkOutput("srl_zero", 32'(zero_flag), 32'h0);
      tick();

      // Illegal op inside a batch
      clear = 1'b1;
      tick();
      clear = 1'b0;
      applyStimulus(ALU_ADD, 16'd7, 1'b0, stalls);
      applyStimulus(4'b0011, 16'd5, 1'b0, stalls);
      applyStimulus(ALU_OR, 16'd8, 1'b1, stalls);
      cmd_valid = 1'b0;
      waitDone(30, cycles);
      checkOutput("ill_latency", 32'(cycles), 32'd5);
      checkOutput("ill_acc", 32'(acc), 32'h000F);
      checkOutput("ill_err", 32'(err), 32'h1);
      tick();

      // clear during EXEC discards the result
      applyStimulus(ALU_ADD, 16'd9, 1'b0 | 1'b1, stalls);
      cmd_valid = 1'b0;
      tick();
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("cx_done", 32'(done), 32'h1);
      checkOutput("cx_acc", 32'(acc), 32'h0);
      checkOutput("cx_zero", 32'(zero_flag), 32'h1);
      checkOutput("cx_err", 32'(err), 32'h0);
      tick();

      // rst during EXEC of a 3-command batch
      applyStimulus(ALU_ADD, 16'd1, 1'b0, stalls);
      applyStimulus(ALU_ADD, 16'd2, 1'b0, stalls);
      applyStimulus(ALU_ADD, 16'd3, 1'b1, stalls);
      cmd_valid = 1'b0;
      rst = 1'b1;
      tick();
      checkResetState("midrst");
      rst = 1'b0;
      sawDone = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) sawDone = 1'b1;
      end
      checkOutput("midrst_no_done", 32'(sawDone), 32'h0);
      checkOutput("midrst_flushed_acc", 32'(acc), 32'h0);
      applyStimulus(ALU_ADD, 16'd4, 1'b0, stalls);
      applyStimulus(ALU_SUB, 16'd1, 1'b1, stalls);
      cmd_valid = 1'b0;
      waitDone(20, cycles);
      checkOutput("post_rst_latency", 32'(cycles), 32'd4);
      checkOutput("post_rst_acc", 32'(acc), 32'h0003);
      tick();

      // Fill the FIFO: 16 back-to-back pushes outrun one pop per two cycles
      rst = 1'b1;
      tick();
      rst = 1'b0;
      totalStalls = 0;
      firstStall  = -1;
      for (int i = 0; i < 16; i++) begin
         applyStimulus((i % 2 == 0) ? ALU_ADD : ALU_SLL, 16'd1, (i == 15), stalls);
         if (stalls > 0 && firstStall < 0) firstStall = i;
         totalStalls += stalls;
      end
      cmd_valid = 1'b0;
      cmd_last  = 1'b0;
      checkOutput("fill_first_stall_idx", 32'(firstStall), 32'd14);
      checkOutput("fill_total_stalls", 32'(totalStalls), 32'd2);
      waitDone(60, cycles);
      checkOutput("fill_done_seen", 32'(cycles > 0), 32'h1);
      checkOutput("fill_acc_order", 32'(acc), 32'h01FE);
      tick();
      checkOutput("fill_ready_after", 32'(cmd_ready), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
